// File: rtl/ci_ram_pkg.sv
// Shared opcodes, valueA field positions, FSM encoding and address-range helper
// for the custom-instruction scratchpad engine.
package ci_ram_pkg;

    localparam logic [2:0] OP_READ  = 3'b000;
    localparam logic [2:0] OP_WRITE = 3'b001;
    localparam logic [2:0] OP_FILL  = 3'b010;
    localparam logic [2:0] OP_SUM   = 3'b011;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 29;
    localparam int CNT_MSB = 27;
    localparam int CNT_LSB = 16;
    localparam int ADR_MSB = 11;

    localparam logic [31:0] ERR_RESULT = 32'hFFFF_FFFF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACCESS,
        ST_FILL,
        ST_SUM_RD,
        ST_SUM_ACC,
        ST_DONE
    } state_t;

    // True when no address bit at or above addr_w is set.
    function automatic logic addr_in_range(input logic [ADR_MSB:0] addr, input int addr_w);
        logic [ADR_MSB:0] hi;
        hi = addr >> addr_w;
        return hi == '0;
    endfunction

endpackage

// File: rtl/ci_ram_sp.sv
// DEPTH x 32 single-port synchronous RAM, read-first, one-cycle read latency,
// no reset so it maps onto block RAM.
module ci_ram_sp #(
    parameter int DEPTH = 512
) (
    input  logic                     clock,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] addr,
    input  logic [31:0]              wdata,
    output logic [31:0]              rdata
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/ci_ram_engine.sv
// Custom-instruction scratchpad: single-word read/write plus multi-cycle
// FILL and SUM over wrapping address ranges, one-cycle done pulse per op.
module ci_ram_engine
    import ci_ram_pkg::*;
#(
    parameter logic [7:0] customId = 8'h00,
    parameter int         DEPTH    = 512
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  ciN,
    input  logic [31:0] valueA,
    input  logic [31:0] valueB,
    output logic        done,
    output logic [31:0] result
);

    localparam int ADDR_W = $clog2(DEPTH);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [11:0]         cnt_q, cnt_d;
    logic [31:0]         data_q, data_d;
    logic [31:0]         acc_q, acc_d;
    logic                rd_pend_q, rd_pend_d;
    logic                done_q, done_d;
    logic [31:0]         result_q, result_d;
    logic                read_sel_q, read_sel_d;

    logic                ram_we;
    logic [ADDR_W-1:0]   ram_addr;
    logic [31:0]         ram_wdata;
    logic [31:0]         ram_rdata;
    logic                unused_fields;

    assign unused_fields = ^{valueA[28], valueA[15:12]};

    ci_ram_sp #(
        .DEPTH(DEPTH)
    ) u_ram (
        .clock(clock),
        .we   (ram_we),
        .addr (ram_addr),
        .wdata(ram_wdata),
        .rdata(ram_rdata)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        cnt_d      = cnt_q;
        data_d     = data_q;
        acc_d      = acc_q;
        rd_pend_d  = 1'b0;
        done_d     = 1'b0;
        result_d   = '0;
        read_sel_d = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = addr_q;
        ram_wdata  = data_q;

        case (state_q)
            ST_IDLE: begin
                if (start && ciN == customId) begin
                    addr_d  = valueA[ADDR_W-1:0];
                    cnt_d   = valueA[CNT_MSB:CNT_LSB];
                    data_d  = valueB;
                    acc_d   = '0;
                    state_d = ST_ACCESS;
                    done_d  = 1'b1;
                    if (!addr_in_range(valueA[ADR_MSB:0], ADDR_W)) begin
                        result_d = ERR_RESULT;
                    end else begin
                        // Single-word ops use the live operand so their RAM access lands on the start edge.
                        case (valueA[OPC_MSB:OPC_LSB])
                            OP_READ: begin
                                ram_addr   = valueA[ADDR_W-1:0];
                                read_sel_d = 1'b1;
                            end
                            OP_WRITE: begin
                                ram_we    = 1'b1;
                                ram_addr  = valueA[ADDR_W-1:0];
                                ram_wdata = valueB;
                            end
                            OP_FILL: begin
                                if (valueA[CNT_MSB:CNT_LSB] != '0) begin
                                    state_d = ST_FILL;
                                    done_d  = 1'b0;
                                end
                            end
                            OP_SUM: begin
                                if (valueA[CNT_MSB:CNT_LSB] != '0) begin
                                    state_d = ST_SUM_RD;
                                    done_d  = 1'b0;
                                end
                            end
                            default: ;
                        endcase
                    end
                end
            end
            ST_FILL: begin
                ram_we = 1'b1;
                addr_d = addr_q + ADDR_W'(1);
                cnt_d  = cnt_q - 12'd1;
                if (cnt_q == 12'd1) begin
                    state_d = ST_DONE;
                    done_d  = 1'b1;
                end
            end
            ST_SUM_RD: begin
                addr_d    = addr_q + ADDR_W'(1);
                cnt_d     = cnt_q - 12'd1;
                rd_pend_d = 1'b1;
                if (rd_pend_q) begin
                    acc_d = acc_q + ram_rdata;
                end
                if (cnt_q == 12'd1) begin
                    state_d = ST_SUM_ACC;
                end
            end
            ST_SUM_ACC: begin
                acc_d    = acc_q + ram_rdata;
                result_d = acc_q + ram_rdata;
                state_d  = ST_DONE;
                done_d   = 1'b1;
            end
            ST_ACCESS, ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            cnt_q      <= '0;
            data_q     <= '0;
            acc_q      <= '0;
            rd_pend_q  <= 1'b0;
            done_q     <= 1'b0;
            result_q   <= '0;
            read_sel_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            cnt_q      <= cnt_d;
            data_q     <= data_d;
            acc_q      <= acc_d;
            rd_pend_q  <= rd_pend_d;
            done_q     <= done_d;
            result_q   <= result_d;
            read_sel_q <= read_sel_d;
        end
    end

    // A READ result comes straight from the RAM output register during its done cycle.
    assign done   = done_q;
    assign result = read_sel_q ? ram_rdata : result_q;

endmodule

// File: tb/tb_ci_ram_engine.sv
// Scoreboard bench for ci_ram_engine: directed scenarios plus random ops checked
// against an array-based reference model.
module tb_ci_ram_engine;

    localparam int         DEPTH = 512;
    localparam logic [7:0] CID   = 8'h00;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  ciN = 8'h00;
    logic [31:0] valueA = '0;
    logic [31:0] valueB = '0;
    logic        done;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic [31:0] res;
        int          due;
        logic [2:0]  op;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model_mem [DEPTH];
    logic        prev_done = 1'b0;

    ci_ram_engine #(
        .customId(CID),
        .DEPTH   (DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .start (start),
        .ciN   (ciN),
        .valueA(valueA),
        .valueB(valueB),
        .done  (done),
        .result(result)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    // Monitor: pops one expectation per done pulse and checks value and timing.
    always @(negedge clock) begin
        exp_t e;
        if (done) begin
            checks++;
            if (prev_done) begin
                errors++;
                $display("[TB] FAIL done_twice cycle %0d: done high two cycles in a row", cyc);
            end
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_done cycle %0d: got result %h, required no done", cyc, result);
            end else begin
                e = sb.pop_front();
                checks++;
                if (result !== e.res || cyc != e.due) begin
                    errors++;
                    $display("[TB] FAIL op%0d_result: got %h at cycle %0d, required %h at cycle %0d",
                             e.op, result, cyc, e.res, e.due);
                end
            end
        end else if (result !== 32'd0) begin
            checks++;
            errors++;
            $display("[TB] FAIL idle_result cycle %0d: got %h, required 0", cyc, result);
        end
        prev_done = done;
    end

    task automatic model_op(input logic [2:0] op, input int n, input int a12, input logic [31:0] d,
                            output logic [31:0] res, output int lat);
        res = 32'd0;
        lat = 1;
        if (a12 >= DEPTH) begin
            res = 32'hFFFF_FFFF;
        end else begin
            case (op)
                3'd0: res = model_mem[a12];
                3'd1: model_mem[a12] = d;
                3'd2: if (n > 0) begin
                    for (int i = 0; i < n; i++) model_mem[(a12 + i) % DEPTH] = d;
                    lat = n + 1;
                end
                3'd3: if (n > 0) begin
                    for (int i = 0; i < n; i++) res = res + model_mem[(a12 + i) % DEPTH];
                    lat = n + 2;
                end
                default: ;
            endcase
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic drive_start(input logic [2:0] op, input int n, input int a12,
                               input logic [31:0] d, input logic [7:0] cid);
        logic [31:0] va;
        va = $urandom;
        va[31:29] = op;
        va[27:16] = n[11:0];
        va[11:0]  = a12[11:0];
        start  = 1'b1;
        ciN    = cid;
        valueA = va;
        valueB = d;
        tick(1);
        start  = 1'b0;
        ciN    = 8'($urandom);
        valueA = $urandom;
        valueB = $urandom;
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        while (sb.size() != 0 && budget < 6000) begin
            tick(1);
            budget++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL done_timeout: got no done after %0d cycles, required %0d pending done", budget, sb.size());
            sb.delete();
        end
    endtask

    task automatic push_expect(input logic [2:0] op, input int n, input int a12, input logic [31:0] d);
        logic [31:0] res;
        int          lat;
        model_op(op, n, a12, d, res, lat);
        sb.push_back('{res: res, due: cyc + lat, op: op});
    endtask

    task automatic apply_stimulus(input logic [2:0] op, input int n, input int a12, input logic [31:0] d);
        push_expect(op, n, a12, d);
        drive_start(op, n, a12, d, CID);
        wait_idle();
    endtask

    task automatic check_output(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, got, want);
        end
    endtask

    initial begin
        logic [31:0] d;
        logic [2:0]  op;
        int          a12;
        int          n;

        tick(3);
        check_output("reset_done", {31'd0, done}, 32'd0);
        check_output("reset_result", result, 32'd0);
        reset = 1'b1;
        tick(1);

        apply_stimulus(3'd2, DEPTH, 0, 32'd0);

        apply_stimulus(3'd1, 0, 5, 32'hDEAD_BEEF);
        apply_stimulus(3'd0, 0, 5, 32'd0);

        apply_stimulus(3'd1, 0, 2, 32'h1234_5678);
        apply_stimulus(3'd2, 4, 510, 32'd7);
        apply_stimulus(3'd0, 0, 510, 32'd0);
        apply_stimulus(3'd0, 0, 511, 32'd0);
        apply_stimulus(3'd0, 0, 0, 32'd0);
        apply_stimulus(3'd0, 0, 1, 32'd0);
        apply_stimulus(3'd0, 0, 2, 32'd0);

        for (int i = 0; i < 8; i++) apply_stimulus(3'd1, 0, 100 + i, 32'(i + 1));
        apply_stimulus(3'd3, 8, 100, 32'd0);
        apply_stimulus(3'd2, 2, 300, 32'hFFFF_FFFF);
        apply_stimulus(3'd3, 2, 300, 32'd0);
        apply_stimulus(3'd3, 5, 509, 32'd0);

        apply_stimulus(3'd0, 0, 12'h200, 32'd0);
        apply_stimulus(3'd1, 0, 12'h3FF, 32'hCAFE_0001);
        apply_stimulus(3'd2, 3, 12'hE00, 32'hCAFE_0002);
        apply_stimulus(3'd0, 0, 12'h1FF, 32'd0);
        apply_stimulus(3'd2, 0, 50, 32'h5555_5555);
        apply_stimulus(3'd3, 0, 50, 32'd0);
        apply_stimulus(3'd5, 7, 50, 32'h5555_5555);
        apply_stimulus(3'd0, 0, 50, 32'd0);

        drive_start(3'd1, 0, 7, 32'hAAAA_AAAA, 8'h01);
        tick(4);
        apply_stimulus(3'd0, 0, 7, 32'd0);

        push_expect(3'd2, 6, 20, 32'h0000_0055);
        drive_start(3'd2, 6, 20, 32'h0000_0055, CID);
        drive_start(3'd1, 0, 21, 32'h0000_0099, CID);
        wait_idle();
        apply_stimulus(3'd0, 0, 21, 32'd0);

        for (int i = 0; i < 10; i++) apply_stimulus(3'd1, 0, i, $urandom);
        d = 32'h0BAD_F00D;
        model_mem[0] = d;
        model_mem[1] = d;
        drive_start(3'd2, 10, 0, d, CID);
        tick(2);
        reset = 1'b0;
        #1;
        check_output("midfill_reset_done", {31'd0, done}, 32'd0);
        check_output("midfill_reset_result", result, 32'd0);
        tick(2);
        reset = 1'b1;
        tick(15);
        for (int i = 0; i < 10; i++) apply_stimulus(3'd0, 0, i, 32'd0);
        apply_stimulus(3'd1, 0, 400, 32'h1357_9BDF);
        apply_stimulus(3'd0, 0, 400, 32'd0);

        for (int k = 0; k < 80; k++) begin
            op  = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(4, 7));
            a12 = ($urandom_range(0, 9) == 0) ? $urandom_range(DEPTH, 4095) : $urandom_range(0, DEPTH - 1);
            n   = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 1) : $urandom_range(0, 24);
            apply_stimulus(op, n, a12, $urandom);
            tick($urandom_range(0, 2));
        end

        tick(3);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ci_ram_engine.md
# ci_ram_engine

Parametrised custom-instruction scratchpad memory with a small built-in engine. The CPU issues custom instructions that read or write single words, fill address ranges, or sum ranges without a per-word CPU loop. It sits on the processor's custom-instruction port next to the other CI blocks and is selected by `customId`. The memory is a DEPTH×32 synchronous single-port RAM; every operation completes with a registered one-cycle `done` pulse.

## Interface
- `customId`, 8'h00, CI number this block answers to.
- `DEPTH`, 512, memory depth in 32-bit words; power of two, 2..4096.
- `ADDR_W`, $clog2(DEPTH), address width; derived, not overridden.

- `clock` in 1: single clock; all logic on the rising edge.
- `reset` in 1: asynchronous, active-low. Asserted (0) clears all control state.
- `start` in 1: CI start strobe, one cycle.
- `ciN` in 8: CI number; the block acts only when `ciN == customId` and `start` = 1.
- `valueA` in 32: `[31:29]` opcode, `[27:16]` count n, `[11:0]` address.
- `valueB` in 32: write/fill data.
- `done` out 1: one-cycle completion pulse (registered).
- `result` out 32: valid only while `done` = 1; otherwise 32'd0.

## Operation
- Opcodes:
  - 3'b000 READ: result = mem[addr].
  - 3'b001 WRITE: mem[addr] = valueB; result = 0.
  - 3'b010 FILL: mem[(addr+i) mod DEPTH] = valueB for i = 0..n-1; result = 0.
  - 3'b011 SUM: result = Σ mem[(addr+i) mod DEPTH] for i = 0..n-1. The sum is 32-bit and wraps modulo 2^32.
  - Other opcodes: no memory access; result = 0.
- Address check: `valueA[11:ADDR_W]` must be zero. If any bit is nonzero, no memory access occurs and result = 32'hFFFF_FFFF.
- `valueA[28]` and `valueA[15:12]` are ignored.
- Address arithmetic wraps modulo DEPTH; FILL and SUM ranges may cross the top of memory.
- n = 0 for FILL or SUM: no access, result = 0, and the op completes in minimum latency.
- FSM states:
  - IDLE: accepts a start.
  - ACCESS: READ/WRITE/other/error ops.
  - FILL: one write per cycle.
  - SUM_RD: issues one read per cycle.
  - SUM_ACC: last accumulate.
  - DONE: drives `done`/`result` for one cycle, then returns to IDLE.
- `start` while not in IDLE, or with a foreign `ciN`, is ignored. No queueing.
- Operand fields are captured on the start edge; later changes to `valueA`/`valueB` have no effect.

## Timing
- Reset values: `done` = 0, `result` = 0, state = IDLE, accumulator = 0, counters = 0. Memory contents are not reset.
- Start accepted in cycle T. Completion:
  - READ / WRITE / other / error / n = 0: `done` in cycle T+1.
  - FILL: one word written per cycle T+1..T+n; `done` at T+n+1.
  - SUM: reads issued T+1..T+n; each datum accumulated one cycle after its read; `done` at T+n+2.
- A WRITE or FILL word is visible to a READ accepted in the cycle after `done`.
- Back-to-back ops: a new start is accepted in the cycle after `done` (state IDLE).
- Reset asserted mid-FILL: words already written stay written, the rest do not. Reset asserted mid-SUM: the result is discarded. In both cases no `done` is produced, and the block is in IDLE when reset is released.
- `done` is never high for two consecutive cycles.

## Structure
- Package `ci_ram_pkg`:
  - opcode localparams OP_READ, OP_WRITE, OP_FILL, OP_SUM
  - state encoding
  - field bit positions (OPC_MSB/LSB, CNT_MSB/LSB, ADR_MSB)
  - ERR_RESULT = 32'hFFFF_FFFF
- Sub-module `ci_ram_sp`: DEPTH×32 single-port synchronous RAM (we, addr, wdata, rdata; 1-cycle read latency, no reset), inferable as block RAM.
- Top level: FSM, address/count registers, accumulator, output registers.

## Test plan
- WRITE addr 5 data 32'hDEADBEEF, then READ addr 5 -> `done` at T+1 each, READ result 32'hDEADBEEF.
- FILL addr 510 n 4 data 7 (DEPTH 512), then READs -> words 510, 511, 0, 1 = 7, word 2 unchanged; `done` at T+5.
- Write 1..8 to addr 100..107, then SUM addr 100 n 8 -> result 36 at T+10. Then SUM over words all 32'hFFFF_FFFF, n 2 -> 32'hFFFF_FFFE.
- READ addr 12'h200 with DEPTH 512 -> result 32'hFFFF_FFFF, memory untouched. FILL n 0 -> `done` at T+1, result 0.
- Ignored starts:
  - start with ciN ≠ customId -> no `done`.
  - start during a FILL -> ignored; only one `done`.
- Reset low at cycle 3 of FILL n 10 at addr 0 -> `done`/`result` 0 immediately, no later `done`, words 0..1 written and 2..9 unchanged. Back-to-back ops after release work.
